// File: rtl/finite_state_machine_if.sv
// Bus between the SPI slave datapath and its control FSM.
// Groups the conditioned SPI strobes, the shift-register taps and
// the FSM's control outputs.
//   master modport : drives cs/sclk_pos/sclk_neg/sr_pout/sr_sout and
//                    observes the strobes, address and miso_q
//   slave modport  : the FSM side (finite_state_machine)
interface finite_state_machine_if #(
  parameter int ADDR_W = 8
);
  logic              cs;
  logic              sclk_pos;
  logic              sclk_neg;
  logic [ADDR_W-1:0] sr_pout;
  logic              sr_sout;
  logic              sr_we;
  logic              dm_we;
  logic              addr_we;
  logic              miso_en;
  logic [ADDR_W-1:0] address;
  logic              miso_q;

  modport master (
    output cs, sclk_pos, sclk_neg, sr_pout, sr_sout,
    input  sr_we, dm_we, addr_we, miso_en, address, miso_q
  );

  modport slave (
    input  cs, sclk_pos, sclk_neg, sr_pout, sr_sout,
    output sr_we, dm_we, addr_we, miso_en, address, miso_q
  );
endinterface

// File: rtl/finite_state_machine.sv
// SPI slave transaction controller.
// Receives an address byte (bit 0 = read flag), then either shifts a
// data byte out on MISO (read) or collects one and strobes the data
// memory (write). Raising cs aborts any transaction.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : finite_state_machine_if.slave
//           in : cs (active-low), sclk_pos, sclk_neg, sr_pout, sr_sout
//           out: sr_we, dm_we, addr_we, miso_en, address, miso_q
module finite_state_machine #(
  parameter int ADDR_W     = 8,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  finite_state_machine_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_STORE,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sr_we;
  logic              dm_we;
  logic              addr_we;
  logic              miso_en;
  logic [ADDR_W-1:0] address;
  logic              miso_q;

  // Outputs are registered alongside the state: each transition sets the
  // strobe belonging to the state being entered, so every output equals
  // a decode of the current state. A counter-complete cycle never
  // increments, so a coincident sclk_pos is dropped rather than carried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr_we   <= 1'b0;
      dm_we   <= 1'b0;
      addr_we <= 1'b0;
      miso_en <= 1'b0;
    end else begin
      sr_we   <= 1'b0;
      dm_we   <= 1'b0;
      addr_we <= 1'b0;
      miso_en <= 1'b0;
      if (bus.cs) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= GET_ADDR;
            bit_cnt <= CNT_W'(bus.sclk_pos);
          end
          GET_ADDR: begin
            if (bit_cnt == CNT_FULL) begin
              state   <= GOT_ADDR;
              bit_cnt <= '0;
              addr_we <= 1'b1;
            end else if (bus.sclk_pos) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          GOT_ADDR: begin
            bit_cnt <= '0;
            if (bus.sr_pout[0]) begin
              state <= READ_LOAD;
              sr_we <= 1'b1;
            end else begin
              state <= WRITE_GET;
            end
          end
          READ_LOAD: begin
            state   <= READ_SHIFT;
            bit_cnt <= '0;
            miso_en <= 1'b1;
          end
          READ_SHIFT: begin
            if (bit_cnt == CNT_FULL) begin
              state   <= DONE;
              bit_cnt <= '0;
            end else begin
              miso_en <= 1'b1;
              if (bus.sclk_pos) begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WRITE_GET: begin
            if (bit_cnt == CNT_FULL) begin
              state   <= WRITE_STORE;
              bit_cnt <= '0;
              dm_we   <= 1'b1;
            end else if (bus.sclk_pos) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          WRITE_STORE: begin
            state   <= DONE;
            bit_cnt <= '0;
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  // The address latch captures the shift register while addr_we is high
  // and otherwise holds, so it survives across transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= '0;
    end else if (addr_we) begin
      address <= bus.sr_pout;
    end
  end

  // MISO is retimed on the SPI falling edge so the tristate buffer sees
  // a stable bit for the master's next rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
    end else if (bus.sclk_neg) begin
      miso_q <= bus.sr_sout;
    end
  end

  assign bus.sr_we   = sr_we;
  assign bus.dm_we   = dm_we;
  assign bus.addr_we = addr_we;
  assign bus.miso_en = miso_en;
  assign bus.address = address;
  assign bus.miso_q  = miso_q;

endmodule

// File: tb/tb_finite_state_machine.sv
// Self-checking bench for finite_state_machine.
// Drives randomized SPI transactions (read/write, random bit spacing,
// random aborts) and checks each one against a transaction-level model:
// how many address, load and store strobes must appear, how many SPI
// clocks see MISO enabled, and what the address latch must hold.
module tb_finite_state_machine;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  // Strobe tallies kept by the monitor; the model compares deltas.
  int   addr_cnt;
  int   sr_cnt;
  int   dm_cnt;
  int   miso_pos_cnt;
  logic exp_miso;
  logic [7:0] exp_addr;

  finite_state_machine_if #(.ADDR_W(8)) bus ();

  finite_state_machine #(
    .ADDR_W     (8),
    .FRAME_BITS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // MISO reference: a bit is taken from sr_sout on every SPI falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_miso <= 1'b0;
    else if (bus.sclk_neg) exp_miso <= bus.sr_sout;
  end

  // Monitor, sampled mid-cycle: tally strobes, check exclusivity and MISO.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.addr_we) addr_cnt++;
      if (bus.sr_we) sr_cnt++;
      if (bus.dm_we) dm_cnt++;
      if (bus.sclk_pos && bus.miso_en) miso_pos_cnt++;
      check_output("strobe_excl",
                   32'($countones({bus.sr_we, bus.dm_we, bus.addr_we}) <= 1), 32'd1);
      check_output("miso_q", 32'(bus.miso_q), 32'(exp_miso));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles between SPI rising edges, with random falling edges.
  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sclk_neg = 1'($urandom_range(1, 0));
      bus.sr_sout  = 1'($urandom_range(1, 0));
      tick();
      bus.sclk_neg = 1'b0;
    end
  endtask

  task automatic pulse_pos();
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
  endtask

  // One transaction. abort_addr/abort_data give the number of SPI rising
  // edges sent in each phase before cs is raised; 8 means no abort.
  task automatic apply_stimulus(input logic [7:0] addr_byte, input int abort_addr,
                                input int abort_data);
    int   a0, s0, d0, m0;
    int   exp_a, exp_s, exp_d, exp_m;
    logic is_read;
    a0 = addr_cnt; s0 = sr_cnt; d0 = dm_cnt; m0 = miso_pos_cnt;
    is_read = addr_byte[0];

    bus.cs = 1'b0;
    if ($urandom_range(1, 0) == 0) tick();
    for (int i = 0; i < abort_addr; i++) begin
      bus.sr_pout = (i == 7) ? addr_byte : 8'($urandom);
      pulse_pos();
      if (i != 7) idle_ticks($urandom_range(3, 1));
    end

    if (abort_addr < 8) begin
      bus.cs = 1'b1;
      idle_ticks(3);
      check_output("addr_abort_hold", 32'(bus.address), 32'(exp_addr));
      exp_a = 0; exp_s = 0; exp_d = 0; exp_m = 0;
    end else begin
      idle_ticks(5);
      exp_addr = addr_byte;
      check_output("addr_latched", 32'(bus.address), 32'(exp_addr));
      for (int k = 0; k < abort_data; k++) begin
        bus.sr_pout = 8'($urandom);
        pulse_pos();
        idle_ticks($urandom_range(3, 1));
      end
      if (abort_data < 8) begin
        bus.cs = 1'b1;
        tick();
        check_output("abort_miso_en", 32'(bus.miso_en), 32'd0);
        idle_ticks(3);
      end else begin
        idle_ticks(3);
        check_output("done_miso_en", 32'(bus.miso_en), 32'd0);
        bus.cs = 1'b1;
        idle_ticks(2);
      end
      exp_a = 1;
      exp_s = is_read ? 1 : 0;
      exp_d = (!is_read && abort_data == 8) ? 1 : 0;
      exp_m = is_read ? abort_data : 0;
    end
    check_output("addr_we_pulses", 32'(addr_cnt - a0), 32'(exp_a));
    check_output("sr_we_pulses", 32'(sr_cnt - s0), 32'(exp_s));
    check_output("dm_we_pulses", 32'(dm_cnt - d0), 32'(exp_d));
    check_output("miso_en_bits", 32'(miso_pos_cnt - m0), 32'(exp_m));
    check_output("addr_final", 32'(bus.address), 32'(exp_addr));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, r, ab_a, ab_d;
    tests_run = 0; tests_failed = 0;
    addr_cnt = 0; sr_cnt = 0; dm_cnt = 0; miso_pos_cnt = 0;
    exp_addr = 8'h00;
    bus.cs = 1'b1; bus.sclk_pos = 1'b0; bus.sclk_neg = 1'b0;
    bus.sr_pout = 8'h00; bus.sr_sout = 1'b0;
    rst_n = 1'b0;
    #23;
    check_output("reset_address", 32'(bus.address), 32'h0);
    check_output("reset_strobes",
                 32'({bus.sr_we, bus.dm_we, bus.addr_we, bus.miso_en, bus.miso_q}), 32'h0);
    rst_n = 1'b1;
    tick();
    idle_ticks(2);

    // Directed write, read and back-to-back sequences.
    apply_stimulus(8'h02, 8, 8);
    apply_stimulus(8'h03, 8, 8);
    d0 = dm_cnt;
    apply_stimulus(8'h02, 8, 4);
    check_output("abort_no_dm_we", 32'(dm_cnt - d0), 32'd0);
    apply_stimulus(8'h02, 8, 8);
    apply_stimulus(8'h02, 8, 8);
    apply_stimulus(8'h03, 8, 8);
    check_output("b2b_address", 32'(bus.address), 32'h03);

    // MISO retiming: loads only on a falling-edge pulse.
    bus.sr_sout = 1'b1; bus.sclk_neg = 1'b1;
    tick();
    bus.sclk_neg = 1'b0; bus.sr_sout = 1'b0;
    check_output("miso_load", 32'(bus.miso_q), 32'd1);
    tick();
    check_output("miso_hold", 32'(bus.miso_q), 32'd1);

    // A ninth rising edge landing on the address-complete cycle is dropped,
    // so the write still needs eight full data edges.
    d0 = dm_cnt;
    bus.cs = 1'b0;
    tick();
    bus.sr_pout = 8'h04;
    for (int i = 0; i < 9; i++) pulse_pos();
    idle_ticks(5);
    for (int k = 0; k < 7; k++) begin
      pulse_pos();
      idle_ticks(2);
    end
    idle_ticks(3);
    check_output("no_carry_7bits", 32'(dm_cnt - d0), 32'd0);
    pulse_pos();
    idle_ticks(3);
    check_output("no_carry_8bits", 32'(dm_cnt - d0), 32'd1);
    bus.cs = 1'b1;
    idle_ticks(2);
    exp_addr = 8'h04;

    // Asynchronous reset in the middle of a read's data phase.
    bus.cs = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.sr_pout = (i == 7) ? 8'h03 : 8'($urandom);
      pulse_pos();
      idle_ticks(1);
    end
    idle_ticks(4);
    for (int k = 0; k < 3; k++) begin
      pulse_pos();
      idle_ticks(1);
    end
    bus.sr_sout = 1'b1; bus.sclk_neg = 1'b1;
    tick();
    bus.sclk_neg = 1'b0;
    check_output("pre_reset_miso_en", 32'(bus.miso_en), 32'd1);
    check_output("pre_reset_miso_q", 32'(bus.miso_q), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.cs = 1'b1;
    #1;
    check_output("async_rst_miso_en", 32'(bus.miso_en), 32'd0);
    check_output("async_rst_address", 32'(bus.address), 32'h0);
    check_output("async_rst_miso_q", 32'(bus.miso_q), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_addr = 8'h00;
    idle_ticks(2);

    // Randomized transactions with occasional aborts.
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(9, 0);
      ab_a = 8; ab_d = 8;
      if (r == 0) ab_a = $urandom_range(7, 1);
      else if (r == 1) ab_d = $urandom_range(7, 1);
      apply_stimulus(8'($urandom), ab_a, ab_d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/finite_state_machine.md
FINITE_STATE_MACHINE -- requirements
Module: finite_state_machine

Interface
REQ-001 Parameter ADDR_W, default 8: width of address latch and parallel shift-register input.
REQ-002 Parameter FRAME_BITS, default 8: sclk rising edges per address byte and per data byte.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cs  input  1  conditioned chip select, active-low.
REQ-006 sclk_pos  input  1  one-clk pulse per SPI clock rising edge.
REQ-007 sclk_neg  input  1  one-clk pulse per SPI clock falling edge.
REQ-008 sr_pout  input  ADDR_W  shift-register parallel output; bit 0 = R/W flag after address byte (1 = read).
REQ-009 sr_sout  input  1  shift-register serial output (MSB).
REQ-010 sr_we  output  1  shift-register parallel-load strobe.
REQ-011 dm_we  output  1  data-memory write strobe.
REQ-012 addr_we  output  1  address-latch load strobe.
REQ-013 miso_en  output  1  MISO tristate enable.
REQ-014 address  output  ADDR_W  latched address.
REQ-015 miso_q  output  1  registered MISO data, fed to the tristate buffer.

Function
REQ-016 States SHALL be IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_STORE, DONE; outputs decoded from state only (Moore).
REQ-017 A bit counter (0..FRAME_BITS) SHALL increment on each sclk_pos in GET_ADDR, READ_SHIFT and WRITE_GET, and clear on every state change.
REQ-018 IDLE: leave for GET_ADDR when cs=0; a sclk_pos in that same cycle SHALL count as bit 1.
REQ-019 GET_ADDR: on counter reaching FRAME_BITS, go to GOT_ADDR.
REQ-020 GOT_ADDR: addr_we=1 for exactly one clk; next state READ_LOAD if sr_pout[0]=1, else WRITE_GET.
REQ-021 READ_LOAD: sr_we=1 for exactly one clk; next READ_SHIFT.
REQ-022 READ_SHIFT: miso_en=1; after FRAME_BITS sclk_pos go to DONE.
REQ-023 WRITE_GET: after FRAME_BITS sclk_pos go to WRITE_STORE.
REQ-024 WRITE_STORE: dm_we=1 for exactly one clk; next DONE.
REQ-025 DONE: all strobes 0; remain until cs=1.
REQ-026 cs=1 in any state SHALL force IDLE on the next clk, clear the counter, drop all strobes; aborted writes SHALL NOT assert dm_we.
REQ-027 Strobes sr_we, dm_we, addr_we SHALL be mutually exclusive and never asserted in IDLE or DONE.
REQ-028 address SHALL load sr_pout on the clk edge where addr_we=1, otherwise hold; it SHALL persist across transactions.
REQ-029 miso_q SHALL load sr_sout on the clk edge where sclk_neg=1, otherwise hold.
REQ-030 A sclk_pos coinciding with the counter-complete transition SHALL NOT be carried into the next state's count.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, sr_we=dm_we=addr_we=miso_en=0, address=0, miso_q=0, regardless of clk.
REQ-032 Reset mid-transaction SHALL abort it with no strobe; operation resumes at next cs falling edge after rst_n=1.

Verification
REQ-033 Write: cs=0, 8 sclk_pos with sr_pout=0x02 at 8th -> one addr_we pulse, address=0x02, 8 more sclk_pos -> one dm_we pulse, miso_en stays 0, then DONE until cs=1.
REQ-034 Read: address byte sr_pout=0x03 -> addr_we pulse, address=0x03, sr_we pulse next clk, miso_en=1 for 8 sclk_pos, then 0.
REQ-035 MISO path: sr_sout=1, sclk_neg pulse -> miso_q=1 next clk; sr_sout=0 without sclk_neg -> miso_q holds 1.
REQ-036 Abort: cs=1 after 4 data bits of a write -> IDLE next clk, dm_we never asserted, address unchanged.
REQ-037 Reset: rst_n=0 during READ_SHIFT -> miso_en=0, address=0x00, miso_q=0 without waiting for clk.
REQ-038 Back-to-back: write 0x55 to address 1, write 0x00 to address 1, read address 1 -> exactly two dm_we pulses, one sr_we pulse, address=0x03 at end.
